// File: rtl/led_pwm_ctrl.sv
// ---------------------------------------------------------------------------
// led_pwm_ctrl
//
// Purpose:
//   Three-channel (R/G/B) LED PWM generator with a small register port and an
//   LED control register. It feeds the LED heartbeat/output mux stage. All
//   outputs are active-high; the LED inversion happens downstream.
//
// Parameters:
//   PRESCALE  clock cycles per PWM counter step (1..65535)
//   DW        duty/counter width; one PWM period is 2^DW steps
//
// Ports:
//   clk      system clock
//   n_reset  synchronous, active-low reset
//   wr_en    write strobe
//   rd_en    read strobe
//   addr     register select: 0=DUTY_R, 1=DUTY_G, 2=DUTY_B, 3=CTRL
//   wdata    write data
//   rdata    registered read data
//   en_hb    CTRL[0], heartbeat mode select for the downstream stage
//   pattern  CTRL[3:1], heartbeat channel mask
//   pwm      PWM waveforms, bit0=R, bit1=G, bit2=B
//
// Optional build macro:
//   LED_PWM_FADE_EN  adds CTRL[4] = fade_en. When set, each active duty moves
//                    one step toward its staging value at every period end
//                    instead of jumping straight to it.
//
// Bus protocol: there is no handshake and no backpressure. Every cycle with
// wr_en=1 performs exactly one write of wdata to addr. Every cycle with
// rd_en=1 loads rdata from addr on that clock edge; the value is valid in the
// following cycle and held until the next read. A read and a write to the
// same address in one cycle return the value from before the write.
// ---------------------------------------------------------------------------
module led_pwm_ctrl #(
   parameter int PRESCALE = 16,
   parameter int DW       = 8
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic       wr_en,
   input  logic       rd_en,
   input  logic [1:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       en_hb,
   output logic [2:0] pattern,
   output logic [2:0] pwm
);

   localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

   logic [15:0]   presc;
   logic [DW-1:0] cnt;
   logic          tick;
   logic          period_end;

   logic [DW-1:0] staging  [3];
   logic [DW-1:0] active   [3];
   logic [DW-1:0] target   [3];
   logic [DW-1:0] load_val [3];

   logic [3:0]    ctrl;
   logic [7:0]    rd_val;

`ifdef LED_PWM_FADE_EN
   logic          fade_en;
`endif

   assign tick       = (presc == PRESC_MAX);
   assign period_end = tick && (cnt == {DW{1'b1}});

   assign en_hb   = ctrl[0];
   assign pattern = ctrl[3:1];

   // Prescaler and step counter run continuously, independent of en_hb.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         presc <= '0;
         cnt   <= '0;
      end else begin
         if (tick) begin
            presc <= '0;
            cnt   <= cnt + DW'(1);
         end else begin
            presc <= presc + 16'd1;
         end
      end
   end

   // The value the active duty takes at period end. A write landing in the
   // period_end cycle must be seen immediately, so the target bypasses the
   // staging register when that channel is being written this cycle.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         target[i] = staging[i];
         if (wr_en && (addr == 2'(i))) begin
            target[i] = DW'(wdata);
         end
         load_val[i] = target[i];
`ifdef LED_PWM_FADE_EN
         if (fade_en) begin
            if (active[i] < target[i]) begin
               load_val[i] = active[i] + DW'(1);
            end else if (active[i] > target[i]) begin
               load_val[i] = active[i] - DW'(1);
            end else begin
               load_val[i] = active[i];
            end
         end
`endif
      end
   end

   // Staging/active duty registers and the registered compare. pwm reflects
   // the cnt/active pair of the previous cycle.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         for (int i = 0; i < 3; i++) begin
            staging[i] <= '0;
            active[i]  <= '0;
         end
         pwm <= 3'b000;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (wr_en && (addr == 2'(i))) begin
               staging[i] <= DW'(wdata);
            end
            if (period_end) begin
               active[i] <= load_val[i];
            end
            pwm[i] <= (cnt < active[i]);
         end
      end
   end

   // CTRL register. Reserved bits are simply not stored.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         ctrl <= 4'hF;
`ifdef LED_PWM_FADE_EN
         fade_en <= 1'b0;
`endif
      end else if (wr_en && (addr == 2'd3)) begin
         ctrl <= wdata[3:0];
`ifdef LED_PWM_FADE_EN
         fade_en <= wdata[4];
`endif
      end
   end

   // Read mux: duty addresses return the staging value.
   always_comb begin
      rd_val = 8'h00;
      case (addr)
         2'd0:    rd_val = 8'(staging[0]);
         2'd1:    rd_val = 8'(staging[1]);
         2'd2:    rd_val = 8'(staging[2]);
         default: begin
            rd_val[3:0] = ctrl;
`ifdef LED_PWM_FADE_EN
            rd_val[4]   = fade_en;
`endif
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         rdata <= 8'h00;
      end else if (rd_en) begin
         rdata <= rd_val;
      end
   end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_pwm_ctrl
//
// Purpose:
//   Self-checking bench for led_pwm_ctrl with PRESCALE=1, so the step counter
//   advances every clock. A bench-side step counter model (m_cnt) tracks the
//   expected value of the DUT step counter. Expected values are pushed into
//   exp_q as each stimulus step is driven and popped when the matching DUT
//   output is sampled. Inputs are driven and outputs sampled on the falling
//   clock edge.
// ---------------------------------------------------------------------------
module tb_led_pwm_ctrl;

   logic       clk = 1'b0;
   logic       n_reset;
   logic       wr_en;
   logic       rd_en;
   logic [1:0] addr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       en_hb;
   logic [2:0] pattern;
   logic [2:0] pwm;

   // ---- clock / reset ----------------------------------------------------
   always #5 clk = ~clk;

   led_pwm_ctrl #(
      .PRESCALE (1),
      .DW       (8)
   ) dut (
      .clk     (clk),
      .n_reset (n_reset),
      .wr_en   (wr_en),
      .rd_en   (rd_en),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .en_hb   (en_hb),
      .pattern (pattern),
      .pwm     (pwm)
   );

   // Reference step counter: resets to 0, then advances once per clock.
   logic [7:0] m_cnt;
   always @(posedge clk) begin
      if (!n_reset) m_cnt <= 8'd0;
      else          m_cnt <= m_cnt + 8'd1;
   end

   // ---- scoreboard -------------------------------------------------------
   logic [15:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [15:0] obs);
      logic [15:0] exp;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s observed=%0h expected=<none queued>", tag, obs);
      end else begin
         exp = exp_q.pop_front();
         assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         end
      end
   endtask

   // ---- driver tasks -----------------------------------------------------
   task automatic do_write(input logic [1:0] a, input logic [7:0] d);
      wr_en = 1'b1;
      addr  = a;
      wdata = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic do_read(input string tag, input logic [1:0] a, input logic [7:0] exp);
      exp_q.push_back(16'(exp));
      rd_en = 1'b1;
      addr  = a;
      @(negedge clk);
      rd_en = 1'b0;
      check(tag, 16'(rdata));
   endtask

   // Bounded wait for the model counter to reach a value.
   task automatic wait_step(input logic [7:0] target);
      int guard = 0;
      while (m_cnt !== target && guard < 600) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 600) begin
         exp_q.push_back(16'(target));
         check("wait_step_timeout", 16'(m_cnt));
      end
   endtask

   // Counts high samples per channel until the first sample of the next
   // period (m_cnt == 1), which is not itself counted.
   int pre_r, pre_g, pre_b;
   task automatic count_to_boundary();
      int guard = 0;
      pre_r = 0; pre_g = 0; pre_b = 0;
      while (m_cnt !== 8'd1 && guard < 600) begin
         if (pwm[0]) pre_r++;
         if (pwm[1]) pre_g++;
         if (pwm[2]) pre_b++;
         @(negedge clk);
         guard++;
      end
      if (guard >= 600) begin
         exp_q.push_back(16'd1);
         check("boundary_timeout", 16'(m_cnt));
      end
   endtask

   // Measures one full PWM period. Sample s (s = 0..255) reflects step cnt=s.
   int hi_r, hi_g, hi_b, rise_r, low_b;
   task automatic measure();
      wait_step(8'd1);
      hi_r = 0; hi_g = 0; hi_b = 0; rise_r = -1; low_b = -1;
      for (int s = 0; s < 256; s++) begin
         if (pwm[0]) begin
            hi_r++;
            if (rise_r < 0) rise_r = s;
         end
         if (pwm[1]) hi_g++;
         if (pwm[2]) hi_b++;
         else        low_b = s;
         @(negedge clk);
      end
   endtask

   // ---- watchdog ---------------------------------------------------------
   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   // ---- directed sequence ------------------------------------------------
   initial begin
      n_reset = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      addr    = 2'd0;
      wdata   = 8'h00;
      repeat (3) @(negedge clk);

      // Reset state
      exp_q.push_back(16'd1);     check("rst_en_hb", 16'(en_hb));
      exp_q.push_back(16'h7);     check("rst_pattern", 16'(pattern));
      exp_q.push_back(16'h0);     check("rst_pwm", 16'(pwm));
      exp_q.push_back(16'h0);     check("rst_rdata", 16'(rdata));
      n_reset = 1'b1;
      @(negedge clk);
      do_read("rd_ctrl_reset", 2'd3, 8'h0F);
      do_read("rd_duty_r_reset", 2'd0, 8'h00);

      // DUTY_R=64 written mid-period: no output until the boundary
      wait_step(8'd100);
      do_write(2'd0, 8'd64);
      count_to_boundary();
      exp_q.push_back(16'd0);     check("r_before_boundary", 16'(pre_r));
      measure();
      exp_q.push_back(16'd64);    check("r_high_64", 16'(hi_r));
      exp_q.push_back(16'd0);     check("r_rise_step", 16'(rise_r));

      // DUTY_G=0, DUTY_B=255
      do_write(2'd1, 8'd0);
      do_write(2'd2, 8'd255);
      measure();
      exp_q.push_back(16'd0);     check("g_duty0_high", 16'(hi_g));
      exp_q.push_back(16'd255);   check("b_duty255_high", 16'(hi_b));
      exp_q.push_back(16'd255);   check("b_low_step", 16'(low_b));
      exp_q.push_back(16'd64);    check("r_still_64", 16'(hi_r));

      // Write landing exactly in the period_end cycle takes effect at once
      wait_step(8'd255);
      do_write(2'd1, 8'd20);
      measure();
      exp_q.push_back(16'd20);    check("g_write_at_period_end", 16'(hi_g));

      // Two writes in one period: last one wins
      do_write(2'd0, 8'd10);
      do_write(2'd0, 8'd200);
      do_read("rd_duty_r_last", 2'd0, 8'd200);
      measure();
      exp_q.push_back(16'd200);   check("r_high_200", 16'(hi_r));
      exp_q.push_back(16'd0);     check("r_rise_200", 16'(rise_r));

      // Read and write to the same address in one cycle
      exp_q.push_back(16'd200);
      wr_en = 1'b1; rd_en = 1'b1; addr = 2'd0; wdata = 8'd77;
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b0;
      check("rd_pre_write", 16'(rdata));
      do_read("rd_post_write", 2'd0, 8'd77);

      // CTRL write: reserved bits dropped
      do_write(2'd3, 8'hF6);
      exp_q.push_back(16'd0);     check("ctrl_en_hb", 16'(en_hb));
      exp_q.push_back(16'h3);     check("ctrl_pattern", 16'(pattern));
`ifdef LED_PWM_FADE_EN
      do_read("rd_ctrl_f6", 2'd3, 8'h16);
`else
      do_read("rd_ctrl_f6", 2'd3, 8'h06);
`endif

      // Reset asserted mid-period
      wait_step(8'd5);
      n_reset = 1'b0;
      @(negedge clk);
      exp_q.push_back(16'h0);     check("midrst_pwm", 16'(pwm));
      exp_q.push_back(16'd1);     check("midrst_en_hb", 16'(en_hb));
      exp_q.push_back(16'h7);     check("midrst_pattern", 16'(pattern));
      exp_q.push_back(16'h0);     check("midrst_rdata", 16'(rdata));
      n_reset = 1'b1;
      @(negedge clk);
      do_write(2'd0, 8'd64);
      count_to_boundary();
      exp_q.push_back(16'd0);     check("post_rst_r_pre", 16'(pre_r));
      exp_q.push_back(16'd0);     check("post_rst_b_pre", 16'(pre_b));
      do_read("post_rst_duty_b", 2'd2, 8'd0);
      measure();
      exp_q.push_back(16'd64);    check("post_rst_r_high", 16'(hi_r));
      exp_q.push_back(16'd0);     check("post_rst_r_rise", 16'(rise_r));
      exp_q.push_back(16'd0);     check("post_rst_b_high", 16'(hi_b));

`ifdef LED_PWM_FADE_EN
      // Fade: active R goes 0 -> 1 -> 2 -> 3 and holds
      do_write(2'd0, 8'd0);
      measure();
      exp_q.push_back(16'd0);     check("fade_r_zero", 16'(hi_r));
      do_write(2'd3, 8'h10);
      do_read("rd_ctrl_fade", 2'd3, 8'h10);
      do_write(2'd0, 8'd3);
      for (int p = 1; p <= 4; p++) begin
         measure();
         exp_q.push_back(16'((p > 3) ? 3 : p));
         check("fade_r_period", 16'(hi_r));
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
